// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detector controller:
// FSM state encoding and the default pattern configuration.
package seq_detect_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default pattern: first-received bit is the MSB
    localparam int unsigned       DEF_PAT_W   = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_detect_ctrl_pattern_matcher.sv
// Serial pattern matcher: keeps the last PAT_W received bits and a fill
// count so a match is only reported once PAT_W bits have been seen since
// the last clear. hit is the combinational match for the bit presented this
// cycle; match is the same event registered into a one-cycle pulse.
module pattern_matcher import seq_detect_pkg::*; #(
    parameter int unsigned          PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0]     PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic data_bit,
    input  logic bit_valid,
    input  logic clear,
    output logic hit,
    output logic match
);

    localparam int unsigned         FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;

    // A single-bit pattern has no older history to shift
    generate
        if (PAT_W == 1) begin : g_hist_one
            assign hist_nxt = data_bit;
        end else begin : g_hist_many
            assign hist_nxt = {hist[PAT_W-2:0], data_bit};
        end
    endgenerate

    assign fill_nxt = (fill == FILL_MAX) ? fill : fill + 1'b1;
    assign hit      = bit_valid && (hist_nxt == PATTERN) && (fill_nxt == FILL_MAX);

    // History, fill count and registered match pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (clear) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= hit;
            if (bit_valid) begin
                hist <= hist_nxt;
                fill <= fill_nxt;
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-serial controller for the pattern detector. Accepts a word over
// valid/ready, shifts it out MSB-first one bit per bit_en tick, counts
// (overlapping) matches with a saturating counter and pulses done when the
// word is consumed.
// Optional build macro SEQ_DETECT_CARRY_HIST_EN: keep matcher history across
// words so patterns straddling a word boundary are detected.
module seq_detect_ctrl import seq_detect_pkg::*; #(
    parameter int unsigned      WORD_W  = 8,
    parameter int unsigned      PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int unsigned      CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              bit_en,
    output logic              cur_bit,
    output logic              busy,
    output logic              match,
    output logic [CNT_W-1:0]  match_count,
    output logic              done
);

    localparam int unsigned       IDX_W    = $clog2(WORD_W + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic              load;
    logic              consume;
    logic              last_bit;
    logic              hit;
    logic              clear;

    assign load     = (state == IDLE) && in_valid;
    assign consume  = (state == SHIFT) && bit_en;
    assign last_bit = (bit_idx == LAST_IDX);

    assign in_ready = (state == IDLE);
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);
    assign cur_bit  = busy ? shreg[WORD_W-1] : 1'b0;

`ifdef SEQ_DETECT_CARRY_HIST_EN
    assign clear = 1'b0;
`else
    assign clear = load;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (bit_en && last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register, bit index and saturating match counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            bit_idx     <= '0;
            match_count <= '0;
        end else if (load) begin
            shreg       <= in_data;
            bit_idx     <= '0;
            match_count <= '0;
        end else if (consume) begin
            shreg   <= {shreg[WORD_W-2:0], 1'b0};
            bit_idx <= bit_idx + 1'b1;
            if (hit && (match_count != {CNT_W{1'b1}})) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

    pattern_matcher #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_matcher (
        .clk       (clk),
        .reset     (reset),
        .data_bit  (cur_bit),
        .bit_valid (consume),
        .clear     (clear),
        .hit       (hit),
        .match     (match)
    );

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed testbench for seq_detect_ctrl: default configuration plus a
// PAT_W=1 / CNT_W=2 instance for counter saturation.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset;

    // Default-parameter DUT
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       bit_en;
    logic       cur_bit;
    logic       busy;
    logic       match;
    logic [3:0] match_count;
    logic       done;

    // Saturation DUT (PAT_W=1, PATTERN=1, CNT_W=2)
    logic [7:0] in_data_b;
    logic       in_valid_b;
    logic       in_ready_b;
    logic       bit_en_b;
    logic       cur_bit_b;
    logic       busy_b;
    logic       match_b;
    logic [1:0] match_count_b;
    logic       done_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bit_en      (bit_en),
        .cur_bit     (cur_bit),
        .busy        (busy),
        .match       (match),
        .match_count (match_count),
        .done        (done)
    );

    seq_detect_ctrl #(
        .WORD_W  (8),
        .PAT_W   (1),
        .PATTERN (1'b1),
        .CNT_W   (2)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data_b),
        .in_valid    (in_valid_b),
        .in_ready    (in_ready_b),
        .bit_en      (bit_en_b),
        .cur_bit     (cur_bit_b),
        .busy        (busy_b),
        .match       (match_b),
        .match_count (match_count_b),
        .done        (done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed one word on the default DUT. bit_en is high on every per-th cycle.
    // mask[k-1] says whether the k-th consumed bit completes the pattern.
    task automatic run_word(input string tag, input logic [7:0] word, input int per,
                            input logic [7:0] mask, input int exp_cnt);
        int consumed;
        int cnt;
        logic exp_m;
        in_data  = word;
        in_valid = 1'b1;
        bit_en   = 1'b0;
        tick();                              // handshake edge
        in_valid = 1'b0;
        chk({tag, "_ready_low"}, in_ready, 1'b0);
        consumed = 0;
        cnt      = 0;
        for (int c = 1; c <= 8 * per; c++) begin
            bit_en = ((c % per) == 0);
            chk({tag, "_busy"}, busy, 1'b1);
            chk({tag, "_cur_bit"}, cur_bit, word[7 - consumed]);
            tick();
            exp_m = 1'b0;
            if (bit_en) begin
                consumed++;
                exp_m = mask[consumed - 1];
                if (exp_m) cnt++;
            end
            chk({tag, "_match"}, match, exp_m);
            chk({tag, "_count"}, match_count, cnt);
            chk({tag, "_done"}, done, (consumed == 8));
        end
        bit_en = 1'b0;
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_final_count"}, match_count, exp_cnt);
        tick();
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_idle_ready"}, in_ready, 1'b1);
        chk({tag, "_count_held"}, match_count, exp_cnt);
    endtask

    initial begin
        int pulses;
        reset      = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        bit_en     = 1'b0;
        in_data_b  = '0;
        in_valid_b = 1'b0;
        bit_en_b   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset values
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_match", match, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_count", match_count, 4'd0);
        chk("rst_cur_bit", cur_bit, 1'b0);

        // Overlapping matches after bits 4 and 7, full speed
        run_word("overlap", 8'b1101_1010, 1, 8'b0100_1000, 2);

        // No match
        run_word("nomatch", 8'hFF, 1, 8'h00, 0);

        // Paced consumption: same result, 24 busy cycles
        run_word("paced", 8'b1101_1010, 3, 8'b0100_1000, 2);

        // Word boundary
        run_word("wb1", 8'b0000_0110, 1, 8'h00, 0);
`ifdef SEQ_DETECT_CARRY_HIST_EN
        run_word("wb2", 8'b1000_0000, 1, 8'h01, 1);
`else
        run_word("wb2", 8'b1000_0000, 1, 8'h00, 0);
`endif

        // Asynchronous reset mid-word
        in_data  = 8'b1101_1010;
        in_valid = 1'b1;
        bit_en   = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();                              // 4th bit consumed: match pending
        chk("mid_match_pre", match, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_match", match, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_count", match_count, 4'd0);
        tick();
        reset  = 1'b0;
        bit_en = 1'b0;
        tick();
        chk("post_rst_ready", in_ready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);

        // Saturation on PAT_W=1 / CNT_W=2; in_valid held high during SHIFT
        in_data_b  = 8'hFF;
        in_valid_b = 1'b1;
        bit_en_b   = 1'b1;
        tick();
        in_data_b = 8'h00;                   // would kill matches if reloaded
        pulses    = 0;
        for (int c = 1; c <= 8; c++) begin
            chk("sat_ready_low", in_ready_b, 1'b0);
            tick();
            if (match_b) pulses++;
            chk("sat_match", match_b, 1'b1);
            chk("sat_count", match_count_b, (c < 3) ? c : 3);
            chk("sat_done", done_b, (c == 8));
        end
        in_valid_b = 1'b0;
        bit_en_b   = 1'b0;
        chk("sat_pulses", pulses, 8);
        tick();
        chk("sat_idle_ready", in_ready_b, 1'b1);
        chk("sat_count_held", match_count_b, 2'd3);
        chk("sat_done_off", done_b, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
